// File: rtl/regfile_if.sv
// Register file access bundle: write port, two read ports, debug read and write counter.
// Combinational reads, one-cycle debug response; the counter is observed as a plain output.
// No backpressure; the debug port is request/acknowledge with an unconditional one-cycle reply.
//
// Signals:
//   we, waddr, wdata          write port (from writeback)
//   re1, raddr1 -> rdata1     read port 1 (decode operand 1)
//   re2, raddr2 -> rdata2     read port 2 (decode operand 2)
//   dbg_req_i, dbg_addr_i     debug read request
//   dbg_ack_o, dbg_data_o     debug read response
//   wr_count_o                count of committed writes
interface regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        dbg_req_i;
  logic [4:0]  dbg_addr_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_data_o;
  logic [31:0] wr_count_o;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_req_i, dbg_addr_i,
    input  rdata1, rdata2, dbg_ack_o, dbg_data_o, wr_count_o
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_req_i, dbg_addr_i,
    output rdata1, rdata2, dbg_ack_o, dbg_data_o, wr_count_o
  );
endinterface

// File: rtl/regfile.sv
// 31 x 32-bit register file (x0 hardwired to zero) with two read ports, a debug read port and a write counter.
// Reads are zero-cycle combinational; debug reads answer one cycle after the request edge.
// No backpressure: every request is acknowledged, back-to-back requests give back-to-back acks.
//
// Ports: clk, rst (async active-high) plus bus (regfile_if.slave):
//   write port we/waddr/wdata, read ports re1/raddr1/rdata1 and re2/raddr2/rdata2,
//   debug port dbg_req_i/dbg_addr_i/dbg_ack_o/dbg_data_o, counter wr_count_o.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
// Without it a same-cycle read returns the old content; the new value appears the next cycle.
module regfile (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_RESP = 1'b1
  } dbg_state_t;

  logic [31:0] regs [1:31];
  logic        wr_commit;
  logic [31:0] wr_cnt;
  logic [31:0] dbg_data_q;
  dbg_state_t  dbg_state;
  dbg_state_t  dbg_state_nxt;
  logic        dbg_ack;

  // x0 writes are dropped here so they never touch storage nor the counter.
  assign wr_commit = bus.we && (bus.waddr != 5'd0);

  // Register array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_commit) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Read port 1
  always_comb begin
    bus.rdata1 = 32'h0;
    if (!rst && bus.re1 && (bus.raddr1 != 5'd0)) begin
      bus.rdata1 = regs[bus.raddr1];
`ifdef REGFILE_BYPASS_EN
      // raddr1 is non-zero here, so a match implies a committing write.
      if (bus.we && (bus.waddr == bus.raddr1)) begin
        bus.rdata1 = bus.wdata;
      end
`endif
    end
  end

  // Read port 2
  always_comb begin
    bus.rdata2 = 32'h0;
    if (!rst && bus.re2 && (bus.raddr2 != 5'd0)) begin
      bus.rdata2 = regs[bus.raddr2];
`ifdef REGFILE_BYPASS_EN
      if (bus.we && (bus.waddr == bus.raddr2)) begin
        bus.rdata2 = bus.wdata;
      end
`endif
    end
  end

  // Committed-write counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= 32'h0;
    end else if (wr_commit) begin
      wr_cnt <= wr_cnt + 32'd1;
    end
  end

  // Debug FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_state <= DBG_IDLE;
    end else begin
      dbg_state <= dbg_state_nxt;
    end
  end

  // Debug FSM: next state and ack
  always_comb begin
    dbg_state_nxt = dbg_state;
    dbg_ack       = 1'b0;
    case (dbg_state)
      DBG_IDLE: begin
        if (bus.dbg_req_i) dbg_state_nxt = DBG_RESP;
      end
      DBG_RESP: begin
        dbg_ack = 1'b1;
        if (!bus.dbg_req_i) dbg_state_nxt = DBG_IDLE;
      end
      default: dbg_state_nxt = DBG_IDLE;
    endcase
  end

  // Debug data is sampled from the array before this edge's write lands,
  // so a colliding write is never forwarded to the debug port. Held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_data_q <= 32'h0;
    end else if (bus.dbg_req_i) begin
      dbg_data_q <= (bus.dbg_addr_i == 5'd0) ? 32'h0 : regs[bus.dbg_addr_i];
    end
  end

  assign bus.dbg_ack_o  = dbg_ack;
  assign bus.dbg_data_o = dbg_data_q;
  assign bus.wr_count_o = wr_cnt;

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning); reset is asynchronous, active-high:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset (RstEnable = 1).
- we  input  1  write enable from the writeback stage.
- waddr  input  5  write register index.
- wdata  input  32  write data.
- re1  input  1  read port 1 enable (decode reg1_read_o).
- raddr1  input  5  read port 1 index (decode reg1_addr_o).
- rdata1  output  32  read port 1 data (decode reg1_data_i).
- re2  input  1  read port 2 enable.
- raddr2  input  5  read port 2 index.
- rdata2  output  32  read port 2 data.
- dbg_req_i  input  1  debug read request.
- dbg_addr_i  input  5  debug read index.
- dbg_ack_o  output  1  debug read response valid.
- dbg_data_o  output  32  debug read data.
- wr_count_o  output  32  count of committed writes.

Function
REQ-002 The block SHALL hold 31 registers of 32 bits (x1..x31); x0 SHALL always read as 0x00000000.
REQ-003 A write SHALL commit on the rising clk edge when rst=0, we=1 and waddr!=0; a write with waddr=0 SHALL be discarded.
REQ-004 Read ports SHALL be combinational (zero-cycle latency): rdataN = 0 when rst=1, reN=0 or raddrN=0; otherwise the register content (subject to REQ-005).
REQ-005 When the bypass feature is compiled in, a read with reN=1, raddrN=waddr!=0 and we=1 in the same cycle SHALL return wdata.
REQ-006 Both read ports SHALL operate independently; identical addresses on both ports SHALL return identical data.
REQ-007 Debug port: handshake is request/acknowledge with one-cycle latency; on an edge where dbg_req_i=1, dbg_ack_o SHALL be 1 in the following cycle and dbg_data_o SHALL hold the register value before that edge's write (x0 -> 0).
REQ-008 dbg_ack_o SHALL be 0 in any cycle not preceded by a sampled dbg_req_i=1; back-to-back requests SHALL produce back-to-back acks; dbg_data_o SHALL hold its last value when dbg_ack_o=0.
REQ-009 Debug state machine: IDLE -> RESP on dbg_req_i=1; RESP -> RESP on dbg_req_i=1; RESP -> IDLE on dbg_req_i=0; IDLE -> IDLE otherwise.
REQ-010 wr_count_o SHALL increment by 1 on every committed write (REQ-003) and wrap 0xFFFFFFFF -> 0x00000000; discarded x0 writes SHALL not count.
REQ-011 A simultaneous write and debug read of the same index SHALL return the pre-write value on dbg_data_o (no bypass on the debug port).

Reset
REQ-012 On rst=1 all registers SHALL clear to 0 asynchronously, regardless of clk.
REQ-013 During reset: rdata1=rdata2=0, dbg_ack_o=0, dbg_data_o=0, wr_count_o=0, debug FSM=IDLE.
REQ-014 Reset asserted mid-request SHALL cancel the pending ack; the first post-reset edge SHALL behave as from IDLE.

Configuration
REQ-015 Macro REGFILE_BYPASS_EN: when defined, REQ-005 write-to-read forwarding SHALL be present; when undefined, same-cycle reads SHALL return the pre-write value and the new value SHALL be visible from the next cycle.

Verification
REQ-016 Reset then read: rst=1, any addresses -> rdata1=rdata2=0, wr_count_o=0, dbg_ack_o=0.
REQ-017 Write x5=0xDEADBEEF, next cycle re1=1 raddr1=5 -> rdata1=0xDEADBEEF, wr_count_o=1; re1=0 -> rdata1=0.
REQ-018 we=1 waddr=0 wdata=0x12345678, then read x0 -> 0x00000000, wr_count_o unchanged.
REQ-019 Same cycle we=1 waddr=7 wdata=0xA5A5A5A5, re2=1 raddr2=7, x7 previously 0x11 -> rdata2=0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x00000011 without.
REQ-020 dbg_req_i=1 for 2 cycles at x3=0x42 -> dbg_ack_o=1 for the 2 following cycles with dbg_data_o=0x42, then 0; rst pulse between request and ack -> no ack.
REQ-021 Preload wr_count_o to 0xFFFFFFFF via writes (or force), one more write to x1 -> wr_count_o=0x00000000.
